// File: rtl/niosii_system_sysid_ext.sv
// ---------------------------------------------------------------------------
// niosii_system_sysid_ext
//
// System-identification slave for the Nios II Avalon-MM fabric. It returns
// the build-time ID, timestamp and feature words. It also provides a
// free-running uptime counter, a byte-writable scratch register and a small
// control register. Reads are registered with a fixed latency of one cycle,
// and there is no waitrequest.
//
// Register map (word addresses):
//   0 SYSID      RO   build system ID
//   1 TIMESTAMP  RO   build timestamp
//   2 UPTIME_LO  RO   uptime[31:0]; the same read latches the high half
//   3 UPTIME_HI  RO   high half latched by the last UPTIME_LO read
//   4 SCRATCH    RW   byte-enabled scratch word
//   5 CONTROL    RW   bit0 EN (count enable), bit1 CLR (write-1 pulse, reads 0)
//   6 FEATURES   RO   feature bitmap
//   7 --         reads 0, writes ignored
//
// Ports:
//   clock          in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   address[2:0]   in   word address
//   read           in   read strobe (dropped if write is also high)
//   write          in   write strobe
//   writedata[31:0]in   write data
//   byteenable[3:0]in   write byte lanes (SCRATCH only)
//   readdata[31:0] out  registered read data, holds between reads
//   readdatavalid  out  one-cycle pulse marking readdata valid
//
// UPTIME_W must lie in 33..64.
// ---------------------------------------------------------------------------
module niosii_system_sysid_ext #(
    parameter logic [31:0] SYSID       = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP   = 32'h0000_0000,
    parameter logic [31:0] FEATURES    = 32'h0000_0000,
    parameter int          UPTIME_W    = 64,
    parameter logic [31:0] SCRATCH_RST = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    typedef enum logic [2:0] {
        ADDR_SYSID     = 3'd0,
        ADDR_TIMESTAMP = 3'd1,
        ADDR_UPTIME_LO = 3'd2,
        ADDR_UPTIME_HI = 3'd3,
        ADDR_SCRATCH   = 3'd4,
        ADDR_CONTROL   = 3'd5,
        ADDR_FEATURES  = 3'd6,
        ADDR_UNMAPPED  = 3'd7
    } reg_addr_e;

    // State
    logic [UPTIME_W-1:0] uptime_q,    uptime_d;
    logic [31:0]         hi_shadow_q, hi_shadow_d;
    logic [31:0]         scratch_q,   scratch_d;
    logic                en_q,        en_d;
    logic [31:0]         readdata_q,  readdata_d;
    logic                rdv_q,       rdv_d;

    reg_addr_e   addr;
    logic        rd_accept;
    logic [63:0] uptime_ext;
    logic [31:0] rd_mux;

    assign addr       = reg_addr_e'(address);
    // A simultaneous write takes priority; the read is silently dropped.
    assign rd_accept  = read & ~write;
    // Zero-extending to 64 bits gives the high half of any legal width.
    assign uptime_ext = 64'(uptime_q);

    // Read multiplexer, sampled from pre-edge state.
    always_comb begin
        // NOTE: every combinational output gets a default first so that no path
        // leaves it unassigned, which would infer a latch.
        rd_mux = 32'h0000_0000;
        unique case (addr)
            ADDR_SYSID:     rd_mux = SYSID;
            ADDR_TIMESTAMP: rd_mux = TIMESTAMP;
            ADDR_UPTIME_LO: rd_mux = uptime_ext[31:0];
            ADDR_UPTIME_HI: rd_mux = hi_shadow_q;
            ADDR_SCRATCH:   rd_mux = scratch_q;
            ADDR_CONTROL:   rd_mux = {31'b0, en_q};
            ADDR_FEATURES:  rd_mux = FEATURES;
            ADDR_UNMAPPED:  rd_mux = 32'h0000_0000;
        endcase
    end

    // Next-state logic
    always_comb begin
        uptime_d    = en_q ? uptime_q + UPTIME_W'(1) : uptime_q;  // wraps silently
        hi_shadow_d = hi_shadow_q;
        scratch_d   = scratch_q;
        en_d        = en_q;
        readdata_d  = readdata_q;
        rdv_d       = rd_accept;

        if (rd_accept) begin
            readdata_d = rd_mux;
            // The high half is latched on the same edge as the low half so that
            // software gets a coherent 64-bit value even across a carry.
            if (addr == ADDR_UPTIME_LO) begin
                hi_shadow_d = uptime_ext[63:32];
            end
        end

        if (write) begin
            if (addr == ADDR_SCRATCH) begin
                for (int b = 0; b < 4; b++) begin
                    if (byteenable[b]) begin
                        scratch_d[b*8 +: 8] = writedata[b*8 +: 8];
                    end
                end
            end
            if (addr == ADDR_CONTROL) begin
                en_d = writedata[0];
                // CLR overrides this edge's increment. The new EN setting
                // takes effect from the next edge.
                if (writedata[1]) begin
                    uptime_d = '0;
                end
            end
        end
    end

    // Registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: every register, including readdata, has a defined reset value,
            // so an in-flight read response is discarded by reset.
            uptime_q    <= '0;
            hi_shadow_q <= 32'h0000_0000;
            scratch_q   <= SCRATCH_RST;
            en_q        <= 1'b1;
            readdata_q  <= 32'h0000_0000;
            rdv_q       <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every register
            // samples the pre-edge values computed above.
            uptime_q    <= uptime_d;
            hi_shadow_q <= hi_shadow_d;
            scratch_q   <= scratch_d;
            en_q        <= en_d;
            readdata_q  <= readdata_d;
            rdv_q       <= rdv_d;
        end
    end

    assign readdata      = readdata_q;
    assign readdatavalid = rdv_q;

endmodule

// File: tb/tb_niosii_system_sysid_ext.sv
// ---------------------------------------------------------------------------
// tb_niosii_system_sysid_ext
//
// Drives one shared bus into two instances: A with a 64-bit uptime and
// SCRATCH_RST=0, and B with a 40-bit uptime and a non-zero SCRATCH_RST.
// A register-level reference model predicts both instances every cycle,
// and directed reads also check hand-computed literals.
// ---------------------------------------------------------------------------
module tb_niosii_system_sysid_ext;

    localparam logic [31:0] P_SYSID = 32'h1A2B_3C4D;
    localparam logic [31:0] P_TS    = 32'h6543_2100;
    localparam logic [31:0] P_FEAT  = 32'h0000_00F5;
    localparam logic [31:0] P_SCR_B = 32'h1234_5678;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        read    = 1'b0;
    logic        write   = 1'b0;
    logic [31:0] writedata  = 32'h0;
    logic [3:0]  byteenable = 4'h0;
    logic [31:0] rd_a, rd_b;
    logic        rdv_a, rdv_b;

    int tests  = 0;
    int errors = 0;

    always #5 clock = ~clock;

    niosii_system_sysid_ext #(
        .SYSID(P_SYSID), .TIMESTAMP(P_TS), .FEATURES(P_FEAT),
        .UPTIME_W(64), .SCRATCH_RST(32'h0000_0000)
    ) dut_a (
        .clock(clock), .reset_n(reset_n), .address(address), .read(read),
        .write(write), .writedata(writedata), .byteenable(byteenable),
        .readdata(rd_a), .readdatavalid(rdv_a)
    );

    niosii_system_sysid_ext #(
        .SYSID(P_SYSID), .TIMESTAMP(P_TS), .FEATURES(P_FEAT),
        .UPTIME_W(40), .SCRATCH_RST(P_SCR_B)
    ) dut_b (
        .clock(clock), .reset_n(reset_n), .address(address), .read(read),
        .write(write), .writedata(writedata), .byteenable(byteenable),
        .readdata(rd_b), .readdatavalid(rdv_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] m_up   [2] = '{64'h0, 64'h0};
    logic [63:0] m_mask [2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_00FF_FFFF_FFFF};
    logic [31:0] m_sh   [2] = '{32'h0, 32'h0};
    logic [31:0] m_scr  [2] = '{32'h0, P_SCR_B};
    logic        m_en   [2] = '{1'b1, 1'b1};
    logic [31:0] e_rd   [2] = '{32'h0, 32'h0};
    logic        e_rdv  [2] = '{1'b0, 1'b0};

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
                m_up[k]  = 64'h0;
                m_sh[k]  = 32'h0;
                m_scr[k] = (k == 0) ? 32'h0 : P_SCR_B;
                m_en[k]  = 1'b1;
                e_rd[k]  = 32'h0;
                e_rdv[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                logic [63:0] nxt;
                e_rdv[k] = read && !write;
                if (e_rdv[k]) begin
                    case (address)
                        3'd0: e_rd[k] = P_SYSID;
                        3'd1: e_rd[k] = P_TS;
                        3'd2: e_rd[k] = m_up[k][31:0];
                        3'd3: e_rd[k] = m_sh[k];
                        3'd4: e_rd[k] = m_scr[k];
                        3'd5: e_rd[k] = {31'b0, m_en[k]};
                        3'd6: e_rd[k] = P_FEAT;
                        default: e_rd[k] = 32'h0;
                    endcase
                    if (address == 3'd2) m_sh[k] = m_up[k][63:32];
                end
                nxt = m_en[k] ? ((m_up[k] + 64'd1) & m_mask[k]) : m_up[k];
                if (write && address == 3'd4) begin
                    for (int b = 0; b < 4; b++)
                        if (byteenable[b]) m_scr[k][b*8 +: 8] = writedata[b*8 +: 8];
                end
                if (write && address == 3'd5) begin
                    m_en[k] = writedata[0];
                    if (writedata[1]) nxt = 64'h0;
                end
                m_up[k] = nxt;
            end
        end
    end

    // One compare process: every cycle out of reset, both instances.
    always @(negedge clock) begin
        if (reset_n) begin
            check("rdv_a", {31'b0, rdv_a}, {31'b0, e_rdv[0]});
            check("rd_a",  rd_a, e_rd[0]);
            check("rdv_b", {31'b0, rdv_b}, {31'b0, e_rdv[1]});
            check("rd_b",  rd_b, e_rd[1]);
        end
    end

    // ---------------- bus tasks (called at a negedge) ----------------
    task automatic bus_read(input logic [2:0] a);
        address = a; read = 1'b1;
        @(negedge clock);
        read = 1'b0;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        address = a; write = 1'b1; writedata = d; byteenable = be;
        @(negedge clock);
        write = 1'b0; byteenable = 4'h0;
    endtask

    logic [31:0] v1;

    initial begin
        repeat (3) @(negedge clock);
        check("reset rdv_a", {31'b0, rdv_a}, 32'h0);
        check("reset rd_a", rd_a, 32'h0);
        reset_n = 1'b1;
        @(negedge clock);

        // 1) ID words and unmapped address
        bus_read(3'd0); check("sysid", rd_a, P_SYSID);
        check("sysid valid", {31'b0, rdv_a}, 32'h1);
        @(negedge clock);
        check("rdv single cycle", {31'b0, rdv_a}, 32'h0);
        check("readdata holds", rd_a, P_SYSID);
        bus_read(3'd1); check("timestamp", rd_a, P_TS);
        bus_read(3'd6); check("features", rd_a, P_FEAT);
        bus_read(3'd7); check("unmapped", rd_a, 32'h0);

        // 2) Scratch byte lanes; RO write ignored
        bus_write(3'd4, 32'hDEAD_BEEF, 4'b0101);
        bus_read(3'd4); check("scratch be0101 a", rd_a, 32'h00AD_00EF);
        check("scratch be0101 b", rd_b, 32'h12AD_56EF);
        bus_write(3'd4, 32'hFFFF_FFFF, 4'b0000);
        bus_read(3'd4); check("scratch be0000", rd_a, 32'h00AD_00EF);
        bus_write(3'd0, 32'h5555_5555, 4'hF);
        bus_read(3'd0); check("sysid after write", rd_a, P_SYSID);

        // 3) Atomic 64-bit read across a low-word rollover (instance A)
        address = 3'd2; read = 1'b1;
        force dut_a.uptime_q = 64'h0000_0001_FFFF_FFFF;
        m_up[0] = 64'h0000_0001_FFFF_FFFF;
        #1 release dut_a.uptime_q;
        @(negedge clock); read = 1'b0;
        check("uptime lo at rollover", rd_a, 32'hFFFF_FFFF);
        bus_read(3'd3); check("uptime hi shadow", rd_a, 32'h0000_0001);

        // 4) Stop, then clear and restart
        bus_write(3'd5, 32'h0, 4'hF);
        bus_read(3'd2); v1 = rd_a;
        repeat (10) @(negedge clock);
        bus_read(3'd2); check("stopped uptime stable", rd_a, v1);
        bus_write(3'd5, 32'h3, 4'hF);
        bus_read(3'd2);
        check("uptime small after clr", {31'b0, rd_a <= 32'd4}, 32'h1);
        bus_read(3'd5); check("control reads en only", rd_a, 32'h1);

        // 5) 40-bit wrap (instance B)
        force dut_b.uptime_q = 40'hFF_FFFF_FFFF;
        m_up[1] = 64'h0000_00FF_FFFF_FFFF;
        #1 release dut_b.uptime_q;
        @(negedge clock);
        bus_read(3'd2); check("b uptime lo after wrap", rd_b, 32'h0);
        bus_read(3'd3); check("b uptime hi after wrap", rd_b, 32'h0);

        // 6) Read+write same cycle, then reset mid-response
        address = 3'd4; read = 1'b1; write = 1'b1;
        writedata = 32'hCAFE_F00D; byteenable = 4'hF;
        @(negedge clock);
        read = 1'b0; write = 1'b0; byteenable = 4'h0;
        check("rd+wr no valid", {31'b0, rdv_a}, 32'h0);
        bus_read(3'd4); check("rd+wr write done", rd_a, 32'hCAFE_F00D);
        address = 3'd0; read = 1'b1;
        @(posedge clock); #1;
        read = 1'b0;
        check("valid before reset", {31'b0, rdv_a}, 32'h1);
        reset_n = 1'b0;
        #1;
        check("async reset rdv", {31'b0, rdv_a}, 32'h0);
        check("async reset rd", rd_a, 32'h0);
        check("async reset rdv b", {31'b0, rdv_b}, 32'h0);
        @(negedge clock); @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("no response after reset", {31'b0, rdv_a}, 32'h0);
        bus_read(3'd4); check("scratch reset a", rd_a, 32'h0);
        check("scratch reset b", rd_b, P_SCR_B);
        bus_read(3'd3); check("shadow reset", rd_a, 32'h0);

        repeat (2) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
